// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: memory-mapped GPIO bank with per-pin direction, atomic
// set/clear/toggle data writes, an input synchroniser, rising/falling edge
// detection with sticky write-1-to-clear status, and a level interrupt.
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   i_sel      chip select
//   i_we       write enable (1 = write, 0 = read)
//   i_addr     byte offset within the bank
//   i_wdata    write data (only [NPINS-1:0] used)
//   o_rdata    combinational read data, 0 unless i_sel & !i_we
//   gpio_pins  bidirectional pads, driven when DIR bit is 1
//   o_irq      high while any STATUS bit is set
module gpio_bank_ctrl #(
  parameter int unsigned NPINS       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic [5:0]        i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  inout  wire  [NPINS-1:0]  gpio_pins,
  output logic              o_irq
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] ADDR_DATA    = AW'(8'h00);
  localparam logic [AW-1:0] ADDR_DIR     = AW'(8'h04);
  localparam logic [AW-1:0] ADDR_READ    = AW'(8'h08);
  localparam logic [AW-1:0] ADDR_SET     = AW'(8'h0C);
  localparam logic [AW-1:0] ADDR_CLR     = AW'(8'h10);
  localparam logic [AW-1:0] ADDR_TGL     = AW'(8'h14);
  localparam logic [AW-1:0] ADDR_RISE_EN = AW'(8'h18);
  localparam logic [AW-1:0] ADDR_FALL_EN = AW'(8'h1C);
  localparam logic [AW-1:0] ADDR_STATUS  = AW'(8'h20);

  // Elaboration-time parameter range guards
  if (NPINS < 1 || NPINS > 32) begin : g_bad_npins
    $error("gpio_bank_ctrl: NPINS must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_bank_ctrl: SYNC_STAGES must be in 2..4");
  end

  // Architectural registers
  logic [NPINS-1:0] r_data;
  logic [NPINS-1:0] r_dir;
  logic [NPINS-1:0] r_rise_en;
  logic [NPINS-1:0] r_fall_en;
  logic [NPINS-1:0] r_status;

  // Input synchroniser chain and the one-cycle-delayed copy of its output
  logic [NPINS-1:0] r_sync [SYNC_STAGES];
  logic [NPINS-1:0] r_prev;

  logic             w_wr;
  logic [NPINS-1:0] w_wd;
  logic [NPINS-1:0] w_sync;
  logic [NPINS-1:0] w_rise;
  logic [NPINS-1:0] w_fall;
  logic [NPINS-1:0] w_status_set;
  logic [NPINS-1:0] w_status_clr;
  logic [NPINS-1:0] w_status_nxt;
  logic [DW-1:0]    w_rdata;
  logic             w_unused_wdata;

  assign w_wr   = i_sel & i_we;
  assign w_wd   = i_wdata[NPINS-1:0];
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Upper write-data bits are ignored when NPINS < 32
  assign w_unused_wdata = ^i_wdata;

  // Pad drivers: output-enabled pins drive DATA, others float
  for (genvar i = 0; i < NPINS; i++) begin : g_pad
    assign gpio_pins[i] = r_dir[i] ? r_data[i] : 1'bz;
  end

  // Metastability synchroniser plus edge-history register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        r_sync[s] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_pins;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= w_sync;
    end
  end

  // Edge detection runs regardless of the enables; enables only gate latching
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  // Sticky status: a same-cycle edge wins over a write-1-to-clear
  always_comb begin
    w_status_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    w_status_clr = '0;
    if (w_wr && (i_addr == ADDR_STATUS)) begin
      w_status_clr = w_wd;
    end
    w_status_nxt = (r_status & ~w_status_clr) | w_status_set;
  end

  // Register-file writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data    <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
    end else begin
      r_status <= w_status_nxt;
      if (w_wr) begin
        case (i_addr)
          ADDR_DATA:    r_data    <= w_wd;
          ADDR_DIR:     r_dir     <= w_wd;
          ADDR_SET:     r_data    <= r_data | w_wd;
          ADDR_CLR:     r_data    <= r_data & ~w_wd;
          ADDR_TGL:     r_data    <= r_data ^ w_wd;
          ADDR_RISE_EN: r_rise_en <= w_wd;
          ADDR_FALL_EN: r_fall_en <= w_wd;
          default:      ;
        endcase
      end
    end
  end

  // Zero-wait-state read mux; write-only and unmapped offsets read 0
  always_comb begin
    w_rdata = '0;
    if (i_sel && !i_we) begin
      case (i_addr)
        ADDR_DATA:    w_rdata = DW'(r_data);
        ADDR_DIR:     w_rdata = DW'(r_dir);
        ADDR_READ:    w_rdata = DW'(w_sync);
        ADDR_RISE_EN: w_rdata = DW'(r_rise_en);
        ADDR_FALL_EN: w_rdata = DW'(r_fall_en);
        ADDR_STATUS:  w_rdata = DW'(r_status);
        default:      w_rdata = '0;
      endcase
    end
  end

  assign o_rdata = w_rdata;
  assign o_irq   = |r_status;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Scoreboard bench for gpio_bank_ctrl (NPINS=8, SYNC_STAGES=2): each read
// pushes its hand-computed expected rdata/irq; a negedge monitor pops and
// compares whenever a read cycle is presented.
module tb_gpio_bank_ctrl;

  localparam logic [5:0] A_DATA   = 6'h00;
  localparam logic [5:0] A_DIR    = 6'h04;
  localparam logic [5:0] A_READ   = 6'h08;
  localparam logic [5:0] A_SET    = 6'h0C;
  localparam logic [5:0] A_CLR    = 6'h10;
  localparam logic [5:0] A_TGL    = 6'h14;
  localparam logic [5:0] A_RISE   = 6'h18;
  localparam logic [5:0] A_FALL   = 6'h1C;
  localparam logic [5:0] A_STATUS = 6'h20;
  localparam logic [5:0] A_UNMAP  = 6'h3C;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_sel = 1'b0;
  logic        i_we = 1'b0;
  logic [5:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_irq;
  wire  [7:0]  gpio_pins;

  logic [7:0]  tb_oe  = 8'hFF;
  logic [7:0]  tb_drv = 8'h00;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  for (genvar i = 0; i < 8; i++) begin : g_tb_pad
    assign gpio_pins[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
  end

  gpio_bank_ctrl #(.NPINS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .i_sel(i_sel), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .gpio_pins(gpio_pins), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: compare every presented read against the scoreboard head
  always @(negedge clk) begin
    if (resetn && i_sel && !i_we) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: addr 0x%02h, got 0x%08h, expected no read", i_addr, o_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        chk({mon_e.name, "_rdata"}, o_rdata, mon_e.rdata);
        chk({mon_e.name, "_irq"}, 32'(o_irq), 32'(mon_e.irq));
      end
    end
  end

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input logic eirq, input string nm);
    sb_q.push_back('{name: nm, rdata: exp, irq: eirq});
    i_sel = 1'b1; i_we = 1'b0; i_addr = a; i_wdata = '0;
    @(posedge clk); #1;
    i_sel = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    #2 chk("rdata_zero_on_write", o_rdata, 32'h0);
    @(posedge clk); #1;
    i_sel = 1'b0; i_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1 chk("rdata_idle_zero", o_rdata, 32'h0);
    chk("irq_reset", 32'(o_irq), 32'h0);
    rd(A_DATA,   32'h00, 1'b0, "rst_data");
    rd(A_DIR,    32'h00, 1'b0, "rst_dir");
    rd(A_STATUS, 32'h00, 1'b0, "rst_status");
    rd(A_READ,   32'h00, 1'b0, "rst_read");

    // Direction and drive: low nibble output, high nibble driven by bench
    tb_drv = 8'h60;
    wr(A_DATA, 32'hA5);
    tb_oe = 8'hF0;
    wr(A_DIR, 32'h0F);
    chk("pins_lo_drive", 32'(gpio_pins[3:0]), 32'h5);
    rd(A_DATA, 32'hA5, 1'b0, "drv_data");
    rd(A_DIR,  32'h0F, 1'b0, "drv_dir");
    rd(A_READ, 32'h65, 1'b0, "drv_read");

    // Atomic set/clear/toggle
    wr(A_DATA, 32'h0F);  rd(A_DATA, 32'h0F, 1'b0, "atom_base");
    wr(A_SET,  32'h30);  rd(A_DATA, 32'h3F, 1'b0, "atom_set");
    wr(A_CLR,  32'h03);  rd(A_DATA, 32'h3C, 1'b0, "atom_clr");
    wr(A_TGL,  32'hFF);  rd(A_DATA, 32'hC3, 1'b0, "atom_tgl");
    wr(A_SET,  32'h00);  rd(A_DATA, 32'hC3, 1'b0, "atom_set_zero");
    wr(A_CLR,  32'h00);  rd(A_DATA, 32'hC3, 1'b0, "atom_clr_zero");
    wr(A_UNMAP, 32'hFF); rd(A_DATA, 32'hC3, 1'b0, "unmap_wr_ignored");
    wr(A_READ, 32'hFF);
    idle(3);
    rd(A_READ, 32'h63, 1'b0, "read_wr_ignored");

    // Synchroniser latency on an input pin
    wr(A_DIR, 32'h00);
    tb_oe = 8'hFF; tb_drv = 8'h00;
    idle(4);
    rd(A_READ, 32'h00, 1'b0, "sync_base");
    tb_drv = 8'h04;
    rd(A_STATUS, 32'h00, 1'b0, "sync_c0_status");
    rd(A_READ,   32'h00, 1'b0, "sync_c1_read_old");
    rd(A_READ,   32'h04, 1'b0, "sync_c2_read_new");
    rd(A_STATUS, 32'h00, 1'b0, "sync_no_latch");

    // Edge interrupts and write-1-to-clear
    tb_drv = 8'h84;
    idle(4);
    wr(A_RISE, 32'h01);
    wr(A_FALL, 32'h80);
    tb_drv = 8'h85;
    rd(A_STATUS, 32'h00, 1'b0, "rise_c0");
    rd(A_READ,   32'h84, 1'b0, "rise_c1");
    rd(A_READ,   32'h85, 1'b0, "rise_c2");
    rd(A_STATUS, 32'h01, 1'b1, "rise_latch");
    tb_drv = 8'h05;
    rd(A_STATUS, 32'h01, 1'b1, "fall_c0");
    rd(A_READ,   32'h85, 1'b1, "fall_c1");
    rd(A_READ,   32'h05, 1'b1, "fall_c2");
    rd(A_STATUS, 32'h81, 1'b1, "fall_latch");
    wr(A_FALL, 32'h00);
    rd(A_STATUS, 32'h81, 1'b1, "en_clear_keeps_status");
    wr(A_STATUS, 32'h01);
    rd(A_STATUS, 32'h80, 1'b1, "w1c_bit0");
    wr(A_STATUS, 32'h80);
    rd(A_STATUS, 32'h00, 1'b0, "w1c_bit7");

    // Same-cycle edge and W1C on bit 0: set wins
    tb_drv = 8'h04; idle(4);
    tb_drv = 8'h05; idle(4);
    rd(A_STATUS, 32'h01, 1'b1, "prio_pre");
    tb_drv = 8'h04; idle(4);
    rd(A_STATUS, 32'h01, 1'b1, "prio_fall_ignored");
    tb_drv = 8'h05;
    idle(2);
    wr(A_STATUS, 32'h01);
    rd(A_STATUS, 32'h01, 1'b1, "prio_set_wins");
    wr(A_STATUS, 32'h01);
    rd(A_STATUS, 32'h00, 1'b0, "prio_clear_after");

    // Reset mid-operation with pending status and an in-flight edge
    tb_drv = 8'h84; idle(4);
    wr(A_FALL, 32'h80);
    tb_drv = 8'h05; idle(4);
    rd(A_STATUS, 32'h81, 1'b1, "pre_rst_status");
    rd(A_UNMAP,  32'h00, 1'b1, "unmapped_read");
    tb_drv = 8'h04; idle(4);
    rd(A_STATUS, 32'h81, 1'b1, "pre_rst_hold");
    tb_drv = 8'h05;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("irq_after_mid_reset", 32'(o_irq), 32'h0);
    rd(A_STATUS, 32'h00, 1'b0, "mid_rst_status");
    idle(4);
    rd(A_STATUS, 32'h00, 1'b0, "mid_rst_no_late_latch");
    rd(A_RISE,   32'h00, 1'b0, "mid_rst_rise_en");
    rd(A_DATA,   32'h00, 1'b0, "mid_rst_data");
    rd(A_DIR,    32'h00, 1'b0, "mid_rst_dir");
    rd(A_READ,   32'h05, 1'b0, "mid_rst_read");
    #1 chk("rdata_desel_zero", o_rdata, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_bank_ctrl.md
# gpio_bank_ctrl

Parametrised GPIO bank for the basicRISCV SoC: NPINS bidirectional pins, memory-mapped on the CPU peripheral bus. It adds atomic set/clear/toggle writes, a metastability synchroniser on pin inputs, per-pin rising/falling edge detection with sticky write-1-to-clear status, and a level interrupt output to the CPU. It replaces the fixed 4-pin GPIO controller and keeps that controller's DATA/DIR/READ offsets.

## Interface
- NPINS, 8, number of GPIO pins, legal 1..32
- SYNC_STAGES, 2, input synchroniser depth, legal 2..4
- clk  input  1  system clock
- resetn  input  1  reset, synchronous, active-low
- i_sel  input  1  chip select
- i_we  input  1  write enable (1 = write, 0 = read)
- i_addr  input  6  byte offset within the bank
- i_wdata  input  32  write data from the CPU
- o_rdata  output  32  read data to the CPU (combinational)
- gpio_pins  inout  NPINS  bidirectional pads
- o_irq  output  1  interrupt, high while any STATUS bit is set

## Operation
- Register map. Unmapped offsets read 0 and ignore writes.
  - 0x00 DATA: rw
  - 0x04 DIR: rw, 1 = output
  - 0x08 READ: ro, synchronised pin state
  - 0x0C SET: wo, DATA |= wdata
  - 0x10 CLR: wo, DATA &= ~wdata
  - 0x14 TGL: wo, DATA ^= wdata
  - 0x18 RISE_EN: rw
  - 0x1C FALL_EN: rw
  - 0x20 STATUS: rw1c
- Only wdata[NPINS-1:0] is used. Reads are zero-extended to 32 bits. Write-only registers read 0.
- Pin drive: gpio_pins[i] = DIR[i] ? DATA[i] : Z.
- Synchroniser: SYNC_STAGES flops per pin sample gpio_pins. The last stage is `sync`. PREV is `sync` delayed one cycle.
  - READ returns `sync`, including pins in output mode. Those reflect the driven value.
- Edge detect:
  - rise = sync & ~PREV
  - fall = ~sync & PREV
- STATUS[i] next value:
  - set if (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])
  - else cleared if a STATUS write has wdata[i] = 1
  - else hold
  - Set has priority over a same-cycle clear.
- Edges are detected whether or not the enables are set. An edge only latches if its enable is 1 in the edge cycle. Clearing an enable does not clear STATUS.
- o_irq = |STATUS (combinational OR of registered bits).
- Read path:
  - o_rdata = 0 when !i_sel or i_we.
  - Fully combinational; no latches.

## Timing
- Writes take effect at the clk edge where i_sel & i_we; the new value is visible on the next cycle. Pins change in that same next cycle.
- Reads: o_rdata is valid in the same cycle as i_sel & !i_we, with zero wait states.
- Pin-to-READ latency: a pin change stable before edge k appears on READ after edge k+SYNC_STAGES-1, i.e. SYNC_STAGES cycles.
- Pin-to-STATUS/o_irq latency: STATUS sets at edge k+SYNC_STAGES, one cycle after READ changes. o_irq rises in the same cycle as STATUS.
- Pulses shorter than one clk period may be missed; this is by design.
- Reset: DATA, DIR, RISE_EN, FALL_EN, STATUS, synchroniser and PREV all go to 0.
  - Outputs: all pins Z, o_irq = 0, o_rdata = 0.
  - A pin held high through reset produces an internal rise edge after reset. It does not latch, because RISE_EN = 0.
- Reset mid-operation: a pending STATUS and an in-flight edge in the synchroniser are discarded. o_irq drops in the cycle after the reset edge.
- SET/CLR/TGL with wdata = 0 leave DATA unchanged.
- A write to READ is ignored.

## Test plan
- Reset then direction/drive:
  - Stimulus: reset; write DIR = 0x0F, DATA = 0xA5.
  - Required: pins[3:0] = 0x5, pins[7:4] = Z. DATA reads 0xA5, DIR reads 0x0F, READ[3:0] = 0x5 after 2 cycles.
- Atomic ops:
  - Stimulus: DATA = 0x0F, then SET 0x30, CLR 0x03, TGL 0xFF.
  - Required: DATA reads 0x3F, then 0x3C, then 0xC3. Each step is visible on the next cycle.
- Synchroniser latency:
  - Stimulus: DIR = 0; bench drives pin 2 high before edge k.
  - Required: READ = 0x04 first at cycle k+2. STATUS stays 0 with enables at 0.
- Edge interrupt and W1C:
  - Stimulus: RISE_EN = 0x01, FALL_EN = 0x80; raise pin 0, then lower pin 7.
  - Required: STATUS = 0x01 at k+2 with o_irq = 1; later STATUS = 0x81. Writing STATUS = 0x01 leaves 0x80. Writing 0x80 gives 0 and o_irq = 0 next cycle.
- Simultaneous set/clear:
  - Stimulus: time the W1C of bit 0 in the same cycle as a new rising edge on pin 0.
  - Required: STATUS[0] stays 1.
- Reset mid-operation and misc:
  - Stimulus: assert resetn low with STATUS = 0x81 and a pin edge in the synchroniser.
  - Required: STATUS = 0 and o_irq = 0 after reset, with no late latch. An unmapped read at 0x3C returns 0. o_rdata = 0 when i_sel = 0.
